// File: rtl/mem_burst_ctrl.sv
// Burst command sequencer for a 16x8 synchronous RAM: expands one read or write
// command into 1..16 single-word accesses at consecutive, wrapping addresses.
module mem_burst_ctrl #(
  parameter int ADDR_WIDTH = 4,
  parameter int DATA_WIDTH = 8
) (
  input  logic                  Clock,
  input  logic                  Reset,
  input  logic                  Cmd_Valid,
  output logic                  Cmd_Ready,
  input  logic                  Cmd_Write,
  input  logic [ADDR_WIDTH-1:0] Cmd_Addr,
  input  logic [ADDR_WIDTH-1:0] Cmd_Len,
  input  logic                  Wr_Valid,
  output logic                  Wr_Ready,
  input  logic [DATA_WIDTH-1:0] Wr_Data,
  output logic                  Rd_Valid,
  output logic [DATA_WIDTH-1:0] Rd_Data,
  output logic [ADDR_WIDTH-1:0] Mem_Address,
  output logic [DATA_WIDTH-1:0] Mem_Data_In,
  output logic                  Mem_WE,
  input  logic [DATA_WIDTH-1:0] Mem_Data_Out
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_WRITE = 2'd1,
    S_READ  = 2'd2,
    S_DRAIN = 2'd3
  } state_t;

  state_t                state_q, state_d;
  logic [ADDR_WIDTH-1:0] ptr_q, ptr_d;
  logic [ADDR_WIDTH-1:0] cnt_q, cnt_d;
  logic [ADDR_WIDTH-1:0] mem_addr_q, mem_addr_d;
  logic [DATA_WIDTH-1:0] mem_din_q, mem_din_d;
  logic                  mem_we_q, mem_we_d;
  logic [1:0]            rd_pipe_q, rd_pipe_d;
  logic                  rd_valid_q, rd_valid_d;
  logic [DATA_WIDTH-1:0] rd_data_q, rd_data_d;

  always_comb begin
    state_d    = state_q;
    ptr_d      = ptr_q;
    cnt_d      = cnt_q;
    mem_addr_d = mem_addr_q;
    mem_din_d  = mem_din_q;
    mem_we_d   = 1'b0;
    rd_pipe_d  = {rd_pipe_q[0], 1'b0};
    // Stage 1 of the pipe marks the cycle the RAM's registered Data_Out is valid.
    rd_valid_d = rd_pipe_q[1];
    rd_data_d  = rd_pipe_q[1] ? Mem_Data_Out : rd_data_q;

    case (state_q)
      S_IDLE: begin
        if (Cmd_Valid) begin
          cnt_d = Cmd_Len;
          if (Cmd_Write) begin
            ptr_d   = Cmd_Addr;
            state_d = S_WRITE;
          end else begin
            // First read address goes out on the acceptance edge itself.
            mem_addr_d   = Cmd_Addr;
            ptr_d        = Cmd_Addr + ADDR_WIDTH'(1);
            rd_pipe_d[0] = 1'b1;
            state_d      = S_READ;
          end
        end else begin
          state_d = S_IDLE;
        end
      end
      S_WRITE: begin
        if (Wr_Valid) begin
          mem_addr_d = ptr_q;
          mem_din_d  = Wr_Data;
          mem_we_d   = 1'b1;
          ptr_d      = ptr_q + ADDR_WIDTH'(1);
          cnt_d      = cnt_q - ADDR_WIDTH'(1);
          state_d    = (cnt_q == '0) ? S_IDLE : S_WRITE;
        end else begin
          state_d = S_WRITE;
        end
      end
      S_READ: begin
        // cnt_q counts addresses still to issue after the one sent on acceptance.
        if (cnt_q == '0) begin
          state_d = S_DRAIN;
        end else begin
          mem_addr_d   = ptr_q;
          ptr_d        = ptr_q + ADDR_WIDTH'(1);
          cnt_d        = cnt_q - ADDR_WIDTH'(1);
          rd_pipe_d[0] = 1'b1;
        end
      end
      S_DRAIN: begin
        if (rd_pipe_q == 2'b00) begin
          state_d = S_IDLE;
        end else begin
          state_d = S_DRAIN;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      state_q    <= S_IDLE;
      ptr_q      <= '0;
      cnt_q      <= '0;
      mem_addr_q <= '0;
      mem_din_q  <= '0;
      mem_we_q   <= 1'b0;
      rd_pipe_q  <= 2'b00;
      rd_valid_q <= 1'b0;
      rd_data_q  <= '0;
    end else begin
      state_q    <= state_d;
      ptr_q      <= ptr_d;
      cnt_q      <= cnt_d;
      mem_addr_q <= mem_addr_d;
      mem_din_q  <= mem_din_d;
      mem_we_q   <= mem_we_d;
      rd_pipe_q  <= rd_pipe_d;
      rd_valid_q <= rd_valid_d;
      rd_data_q  <= rd_data_d;
    end
  end

  assign Cmd_Ready   = (state_q == S_IDLE);
  assign Wr_Ready    = (state_q == S_WRITE);
  assign Mem_Address = mem_addr_q;
  assign Mem_Data_In = mem_din_q;
  assign Mem_WE      = mem_we_q;
  assign Rd_Valid    = rd_valid_q;
  assign Rd_Data     = rd_data_q;

endmodule

// File: doc/mem_burst_ctrl.md
# mem_burst_ctrl

Burst command sequencer that sits directly upstream of the 16x8 synchronous read/write memory and drives its Address, Data_In and WE pins. It accepts one read or write command at a time via a valid/ready handshake and expands it into 1–16 single-word memory accesses at consecutive addresses, with wrap-around. Write words arrive on a handshaked input stream. Read words are captured from the memory's registered Data_Out and returned as a pulsed output stream.

## Interface
- ADDR_WIDTH, 4, memory address width; depth is 2^ADDR_WIDTH
- DATA_WIDTH, 8, memory word width

- Clock  in  1  single clock; all state changes on posedge
- Reset  in  1  asynchronous, active-high
- Cmd_Valid  in  1  command offered
- Cmd_Ready  out  1  controller can accept a command (high in IDLE)
- Cmd_Write  in  1  1 = write burst, 0 = read burst
- Cmd_Addr  in  ADDR_WIDTH  start address
- Cmd_Len  in  ADDR_WIDTH  burst length minus 1 (0 → 1 word, 15 → 16 words)
- Wr_Valid  in  1  write word offered
- Wr_Ready  out  1  write word accepted this cycle (high in WRITE)
- Wr_Data  in  DATA_WIDTH  write word
- Rd_Valid  out  1  Rd_Data holds a returned word (one-cycle pulse per word; no backpressure)
- Rd_Data  out  DATA_WIDTH  returned read word
- Mem_Address  out  ADDR_WIDTH  to memory Address
- Mem_Data_In  out  DATA_WIDTH  to memory Data_In
- Mem_WE  out  1  to memory WE

## Operation
- States: IDLE, WRITE, READ, DRAIN. Cmd_Ready = (state==IDLE); Wr_Ready = (state==WRITE).
- IDLE: on Cmd_Valid&&Cmd_Ready, latch Cmd_Addr into the address pointer and Cmd_Len into the beat counter, then go to WRITE (Cmd_Write=1) or READ (Cmd_Write=0).
- READ entry: at the acceptance edge, drive Mem_Address=Cmd_Addr with Mem_WE=0.
- WRITE: on each Wr_Valid&&Wr_Ready edge, register Mem_Address=pointer, Mem_Data_In=Wr_Data, Mem_WE=1 for exactly the following cycle.
  - Pointer increments mod 2^ADDR_WIDTH. Counter decrements.
  - When the accepted beat is the last (counter==0), go to IDLE.
  - A cycle with no accepted beat drives Mem_WE=0.
- READ: issue one address per cycle with Mem_WE=0; pointer increments mod 2^ADDR_WIDTH. After issuing the last address (counter==0), go to DRAIN.
- DRAIN: wait until the 2-stage read-valid pipeline is empty, then go to IDLE.
- Read return: a 2-bit valid shift pipe tracks issued reads. At the edge two cycles after an address was issued, capture the memory's Data_Out into Rd_Data and assert Rd_Valid for one cycle.
- Mem_WE is 0 in every state except the cycle after an accepted write beat. The memory reads every non-write cycle; this is harmless.
- Addresses wrap: Cmd_Addr=14, Cmd_Len=3 accesses 14,15,0,1.
- Cmd_* inputs are ignored outside IDLE. Wr_* inputs are ignored outside WRITE.

## Timing
- Reset (async, immediate):
  - state=IDLE, so Cmd_Ready=1 and Wr_Ready=0.
  - Mem_WE=0, Mem_Address=0, Mem_Data_In=0.
  - Rd_Valid=0, Rd_Data=0, read pipe cleared.
- Reset mid-burst: the burst is abandoned and pending read returns are dropped. Mem_WE drops asynchronously, so no memory write occurs on the next edge.
- Write: Wr_Ready rises the cycle after command acceptance. Best case, an N-word write completes in N cycles plus 1 memory-write cycle. Cmd_Ready returns in the cycle after the last beat edge.
- Back-to-back: a command accepted on the edge where the final write lands in memory is legal. A following read of that address returns the new data (write edge precedes the read-sample edge).
- Read: with command accepted at edge c, word i gets Rd_Valid high after edge c+2+i. Words arrive on consecutive cycles. Cmd_Ready returns after edge c+N+2 (the cycle after the last Rd_Valid).

## Test plan
- Reset during WRITE with Mem_WE=1 → Mem_WE, Rd_Valid, Wr_Ready drop immediately; Cmd_Ready=1; the addressed location keeps its prior value.
- Write burst Addr=2, Len=0, Wr_Data=8'hAA; then read Addr=2, Len=0 → Mem_WE high for one cycle with Mem_Address=2; one Rd_Valid pulse, Rd_Data=8'hAA, 2 cycles after read acceptance.
- Write Addr=14, Len=3, data 8'h11,22,33,44 with Wr_Valid gaps; read Addr=14, Len=3 → Mem_Address sequence 14,15,0,1; Rd_Data 11,22,33,44 on 4 consecutive cycles.
- Full 16-word write of 8'h00..8'h0F from Addr=0, then read Addr=5, Len=15 → 16 words 05..0F,00..04; Cmd_Ready low throughout; no extra Rd_Valid.
- Read command accepted on the edge right after the last write beat, same address → read returns the newly written value.
- Cmd_Valid held high during a burst and Wr_Valid toggled during READ → no second command accepted early, Mem_WE stays 0 during READ/DRAIN.
